// File: rtl/spi_cmd_controller_pkg.sv
// ============================================================================
//  spi_cmd_controller_pkg
//  Opcodes, FSM state encoding and status-byte helper for the SPI command
//  controller of the display subsystem.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package spi_cmd_controller_pkg;

   localparam logic [7:0] OP_WRITE_FB    = 8'h01;
   localparam logic [7:0] OP_SET_BRIGHT  = 8'h02;
   localparam logic [7:0] OP_SET_CTRL    = 8'h03;
   localparam logic [7:0] OP_READ_STATUS = 8'h04;

   localparam logic [7:0] BRIGHT_RESET   = 8'h80;
   localparam logic [3:0] ERR_MAX        = 4'hF;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR_HI = 3'd1,
      ADDR_LO = 3'd2,
      DATA    = 3'd3,
      REG     = 3'd4,
      DISCARD = 3'd5
   } state_t;

   function automatic logic [7:0] status_byte(input logic en, input logic [3:0] errs);
      return {en, 3'b000, errs};
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_cmd_controller.sv
// ============================================================================
//  spi_cmd_controller
//  Decodes SPI command frames into framebuffer writes and display registers.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module spi_cmd_controller
   import spi_cmd_controller_pkg::*;
#(
   parameter int FB_AW = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ss,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic [7:0]       tx_data,
   output logic             fb_we,
   output logic [FB_AW-1:0] fb_addr,
   output logic [7:0]       fb_wdata,
   output logic [7:0]       brightness,
   output logic             disp_en,
   output logic [3:0]       err_count
);

   state_t           state;
   logic [FB_AW-1:0] ptr;
   logic [7:0]       addr_hi;
   logic             ctrl_sel;
   logic             status_mode;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         ptr         <= '0;
         addr_hi     <= 8'h00;
         ctrl_sel    <= 1'b0;
         status_mode <= 1'b0;
         tx_data     <= 8'h00;
         fb_we       <= 1'b0;
         fb_addr     <= '0;
         fb_wdata    <= 8'h00;
         brightness  <= BRIGHT_RESET;
         disp_en     <= 1'b0;
         err_count   <= 4'h0;
      end else begin
         fb_we <= 1'b0;
         if (!ss) begin
            // Frame end aborts whatever command was in flight.
            state       <= IDLE;
            status_mode <= 1'b0;
         end else if (rx_valid) begin
            tx_data <= status_mode ? status_byte(disp_en, err_count) : rx_data;
            case (state)
               IDLE: begin
                  ctrl_sel <= (rx_data == OP_SET_CTRL);
                  case (rx_data)
                     OP_WRITE_FB:                state <= ADDR_HI;
                     OP_SET_BRIGHT, OP_SET_CTRL: state <= REG;
                     OP_READ_STATUS: begin
                        state       <= DISCARD;
                        status_mode <= 1'b1;
                        tx_data     <= status_byte(disp_en, err_count);
                     end
                     default: begin
                        state <= DISCARD;
                        if (err_count != ERR_MAX)
                           err_count <= err_count + 4'd1;
                     end
                  endcase
               end
               ADDR_HI: begin
                  addr_hi <= rx_data;
                  state   <= ADDR_LO;
               end
               ADDR_LO: begin
                  ptr   <= FB_AW'({addr_hi, rx_data});
                  state <= DATA;
               end
               DATA: begin
                  fb_we    <= 1'b1;
                  fb_addr  <= ptr;
                  fb_wdata <= rx_data;
                  ptr      <= ptr + FB_AW'(1);
               end
               REG: begin
                  if (ctrl_sel)
                     disp_en <= rx_data[0];
                  else
                     brightness <= rx_data;
                  state <= DISCARD;
               end
               default: state <= DISCARD;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_controller.sv
// ============================================================================
//  tb_spi_cmd_controller
//  Vector table, directed corner sequences and random frames vs. a frame model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spi_cmd_controller;

   localparam int FB_AW = 12;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             ss = 1'b0;
   logic [7:0]       rx_data = 8'h00;
   logic             rx_valid = 1'b0;
   logic [7:0]       tx_data;
   logic             fb_we;
   logic [FB_AW-1:0] fb_addr;
   logic [7:0]       fb_wdata;
   logic [7:0]       brightness;
   logic             disp_en;
   logic [3:0]       err_count;

   spi_cmd_controller #(.FB_AW(FB_AW)) dut (
      .clk(clk), .rst(rst), .ss(ss), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
      .brightness(brightness), .disp_en(disp_en), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Frame-level reference: byte position within frame decides meaning.
   int         idx;
   logic [7:0] op;
   logic [7:0] hi;
   int         m_ptr;
   logic       m_we;
   int         m_addr;
   logic [7:0] m_wd, m_tx, m_bright;
   logic       m_en;
   logic [3:0] m_err;

   task automatic model_reset();
      idx = 0; op = 8'h00; hi = 8'h00; m_ptr = 0;
      m_we = 1'b0; m_addr = 0; m_wd = 8'h00; m_tx = 8'h00;
      m_bright = 8'h80; m_en = 1'b0; m_err = 4'h0;
   endtask

   task automatic model(input logic s, input logic v, input logic [7:0] d);
      m_we = 1'b0;
      if (!s) begin
         idx = 0;
      end else if (v) begin
         if (idx == 0) begin
            op   = d;
            m_tx = d;
            if (d == 8'h04)
               m_tx = {m_en, 3'b000, m_err};
            else if (d == 8'h00 || d > 8'h04)
               m_err = (m_err == 4'd15) ? m_err : m_err + 4'd1;
         end else begin
            m_tx = (op == 8'h04) ? {m_en, 3'b000, m_err} : d;
            if (op == 8'h01) begin
               if (idx == 1) hi = d;
               else if (idx == 2) m_ptr = (int'(hi) * 256 + int'(d)) % (1 << FB_AW);
               else begin
                  m_we   = 1'b1;
                  m_addr = m_ptr;
                  m_wd   = d;
                  m_ptr  = (m_ptr + 1) % (1 << FB_AW);
               end
            end else if (op == 8'h02 && idx == 1) m_bright = d;
            else if (op == 8'h03 && idx == 1) m_en = d[0];
         end
         idx++;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all();
      chk("fb_we",      32'(fb_we),      32'(m_we));
      chk("fb_addr",    32'(fb_addr),    32'(m_addr));
      chk("fb_wdata",   32'(fb_wdata),   32'(m_wd));
      chk("tx_data",    32'(tx_data),    32'(m_tx));
      chk("brightness", 32'(brightness), 32'(m_bright));
      chk("disp_en",    32'(disp_en),    32'(m_en));
      chk("err_count",  32'(err_count),  32'(m_err));
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic step(input logic s, input logic v, input logic [7:0] d, input bit do_chk);
      ss = s; rx_valid = v; rx_data = d;
      @(posedge clk);
      #1;
      model(s, v, d);
      if (do_chk) check_all();
      @(negedge clk);
   endtask

   task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input int nb);
      if (nb > 0) step(1'b1, 1'b1, b0, 1'b1);
      if (nb > 1) step(1'b1, 1'b1, b1, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   typedef struct {
      logic       s;
      logic       v;
      logic [7:0] d;
      logic       we;
      logic [11:0] addr;
      logic [7:0] wd;
      logic [7:0] tx;
   } vec_t;

   vec_t tbl [12];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 8'h01, 1'b0, 12'h000, 8'h00, 8'h01};
      tbl[1]  = '{1'b1, 1'b1, 8'h00, 1'b0, 12'h000, 8'h00, 8'h00};
      tbl[2]  = '{1'b1, 1'b1, 8'h10, 1'b0, 12'h000, 8'h00, 8'h10};
      tbl[3]  = '{1'b1, 1'b1, 8'hAA, 1'b1, 12'h010, 8'hAA, 8'hAA};
      tbl[4]  = '{1'b1, 1'b1, 8'hBB, 1'b1, 12'h011, 8'hBB, 8'hBB};
      tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h011, 8'hBB, 8'hBB};
      tbl[6]  = '{1'b1, 1'b1, 8'h01, 1'b0, 12'h011, 8'hBB, 8'h01};
      tbl[7]  = '{1'b1, 1'b1, 8'h0F, 1'b0, 12'h011, 8'hBB, 8'h0F};
      tbl[8]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 12'h011, 8'hBB, 8'hFF};
      tbl[9]  = '{1'b1, 1'b1, 8'h11, 1'b1, 12'hFFF, 8'h11, 8'h11};
      tbl[10] = '{1'b1, 1'b1, 8'h22, 1'b1, 12'h000, 8'h22, 8'h22};
      tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h000, 8'h22, 8'h22};

      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst = 1'b1;
      @(negedge clk);

      // Table: two framebuffer-write frames including pointer wrap.
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].s, tbl[i].v, tbl[i].d, 1'b0);
         chk($sformatf("tbl%0d fb_we", i),    32'(fb_we),    32'(tbl[i].we));
         chk($sformatf("tbl%0d fb_addr", i),  32'(fb_addr),  32'(tbl[i].addr));
         chk($sformatf("tbl%0d fb_wdata", i), 32'(fb_wdata), 32'(tbl[i].wd));
         chk($sformatf("tbl%0d tx_data", i),  32'(tx_data),  32'(tbl[i].tx));
      end

      // Register writes; trailing bytes are discarded.
      frame(8'h02, 8'h40, 2);
      chk("bright_0x40", 32'(brightness), 32'h40);
      step(1'b1, 1'b1, 8'h03, 1'b1);
      step(1'b1, 1'b1, 8'h01, 1'b1);
      step(1'b1, 1'b1, 8'h00, 1'b1);
      step(1'b1, 1'b1, 8'h99, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("disp_en_set", 32'(disp_en),    32'h1);
      chk("bright_keep", 32'(brightness), 32'h40);

      // ss drop mid write-command, then a register frame.
      step(1'b1, 1'b1, 8'h01, 1'b1);
      step(1'b1, 1'b1, 8'h00, 1'b1);
      step(1'b0, 1'b1, 8'h33, 1'b1);
      frame(8'h02, 8'h55, 2);
      chk("bright_0x55", 32'(brightness), 32'h55);

      // Error saturation and status read.
      for (int i = 0; i < 17; i++) frame(8'h7E, 8'h00, 1);
      chk("err_sat", 32'(err_count), 32'hF);
      frame(8'h04, 8'h00, 2);
      chk("status_en1", 32'(tx_data), 32'h8F);
      frame(8'h03, 8'h00, 2);
      frame(8'h04, 8'h00, 2);
      chk("status_en0", 32'(tx_data),   32'h0F);
      chk("status_noerr", 32'(err_count), 32'hF);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("empty_frame", 32'(err_count), 32'hF);

      // Asynchronous reset in the middle of a data phase.
      step(1'b1, 1'b1, 8'h01, 1'b1);
      step(1'b1, 1'b1, 8'h02, 1'b1);
      step(1'b1, 1'b1, 8'h00, 1'b1);
      step(1'b1, 1'b1, 8'hC3, 1'b1);
      rx_valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      model_reset();
      chk("rst fb_we",      32'(fb_we),      32'h0);
      chk("rst fb_addr",    32'(fb_addr),    32'h0);
      chk("rst fb_wdata",   32'(fb_wdata),   32'h0);
      chk("rst tx_data",    32'(tx_data),    32'h0);
      chk("rst brightness", 32'(brightness), 32'h80);
      chk("rst disp_en",    32'(disp_en),    32'h0);
      chk("rst err_count",  32'(err_count),  32'h0);
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, 1'b1, 8'hAA, 1'b1);
      chk("post_rst_no_we", 32'(fb_we), 32'h0);
      step(1'b1, 1'b1, 8'hAB, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);

      // Random frames against the frame model.
      for (int f = 0; f < 250; f++) begin
         int nb;
         int r;
         logic [7:0] d;
         nb = $urandom_range(0, 7);
         for (int b = 0; b < nb; b++) begin
            if (b == 0) begin
               r = $urandom_range(0, 9);
               d = (r < 8) ? 8'(r % 4 + 1) : 8'($urandom);
            end else begin
               d = 8'($urandom);
            end
            repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 8'($urandom), 1'b1);
            step(1'b1, 1'b1, d, 1'b1);
         end
         step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
